// File: rtl/gigerx_bcnt_fifo_sc.sv
// Single-clock byte-count FIFO between the receive byte counter and the
// descriptor/length consumer. Optional show-ahead read port, programmable
// almost-full/almost-empty levels, synchronous flush, sticky error flags.
module gigerx_bcnt_fifo_sc #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PTR      = 8,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = 240,
  parameter int unsigned AE_LEVEL = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             almost_full,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CW       = PTR + 1;
  // Levels above DEPTH behave as DEPTH so the compare never truncates.
  localparam int unsigned AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
  localparam int unsigned AE_CLAMP = (AE_LEVEL > DEPTH) ? DEPTH : AE_LEVEL;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW-1:0]    usedw_nxt;

  // Accept decisions use the registered flags; next occupancy follows.
  always_comb begin
    wr_acc    = wrreq & ~full;
    rd_acc    = rdreq & ~empty;
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc) begin
      usedw_nxt = usedw + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      usedw_nxt = usedw - CW'(1);
    end
  end

  // Pointers, occupancy and status flags; flags track the new occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR'(1);
      usedw        <= usedw_nxt;
      empty        <= (usedw_nxt == CW'(0));
      full         <= (usedw_nxt == CW'(DEPTH));
      almost_empty <= (usedw_nxt <= CW'(AE_CLAMP));
      almost_full  <= (usedw_nxt >= CW'(AF_CLAMP));
      overflow     <= overflow | (wrreq & full);
      underflow    <= underflow | (rdreq & empty);
    end
  end

  // Storage array, not reset; a flush cycle drops the write.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr] <= data;
    end
  end

  if (FWFT != 0) begin : g_show_ahead
    // Head word presented directly; rdreq only acknowledges it.
    assign q = mem[rd_ptr];
  end else begin : g_normal
    logic [WIDTH-1:0] q_r;
    // Registered read data, one cycle after an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r <= '0;
      end else if (clr) begin
        q_r <= '0;
      end else if (rd_acc) begin
        q_r <= mem[rd_ptr];
      end
    end
    assign q = q_r;
  end

endmodule

// File: tb/tb_gigerx_bcnt_fifo_sc.sv
// Bench for gigerx_bcnt_fifo_sc: a normal-read and a show-ahead instance
// share stimulus; a queue model supplies every expected value.
module tb_gigerx_bcnt_fifo_sc;

  localparam int unsigned W   = 16;
  localparam int unsigned D   = 16;
  localparam int unsigned P   = 4;
  localparam int unsigned AFL = 12;
  localparam int unsigned AEL = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         wrreq = 1'b0;
  logic         rdreq = 1'b0;
  logic [W-1:0] data = '0;

  logic         full0, afull0, empty0, aempty0, ovf0, unf0;
  logic [W-1:0] q0;
  logic [P:0]   usedw0;
  logic         full1, afull1, empty1, aempty1, ovf1, unf1;
  logic [W-1:0] q1;
  logic [P:0]   usedw1;

  gigerx_bcnt_fifo_sc #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(0),
                        .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrreq(wrreq), .data(data),
    .full(full0), .almost_full(afull0), .rdreq(rdreq), .q(q0),
    .empty(empty0), .almost_empty(aempty0), .usedw(usedw0),
    .overflow(ovf0), .underflow(unf0));

  gigerx_bcnt_fifo_sc #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(1),
                        .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrreq(wrreq), .data(data),
    .full(full1), .almost_full(afull1), .rdreq(rdreq), .q(q1),
    .empty(empty1), .almost_empty(aempty1), .usedw(usedw1),
    .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: words pushed on accepted writes, popped on accepted reads.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic [W-1:0] m_q   = '0;

  typedef struct {
    logic         wr;
    logic         rd;
    logic         cl;
    logic [W-1:0] d;
    logic [P:0]   e_usedw;
    logic         e_empty;
    logic         e_ae;
    logic         e_unf;
    logic         chk_q;
    logic [W-1:0] e_q;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_q   = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".usedw"},   32'(usedw0),  32'(n));
    chk({tag, ".empty"},   32'(empty0),  32'(n == 0));
    chk({tag, ".full"},    32'(full0),   32'(n == D));
    chk({tag, ".aempty"},  32'(aempty0), 32'(n <= AEL));
    chk({tag, ".afull"},   32'(afull0),  32'(n >= AFL));
    chk({tag, ".ovf"},     32'(ovf0),    32'(m_ovf));
    chk({tag, ".unf"},     32'(unf0),    32'(m_unf));
    chk({tag, ".q"},       32'(q0),      32'(m_q));
    chk({tag, ".usedw_sa"}, 32'(usedw1), 32'(n));
    chk({tag, ".unf_sa"},  32'(unf1),    32'(m_unf));
    if (n != 0) chk({tag, ".q_sa"}, 32'(q1), 32'(mq[0]));
  endtask

  // One clock of stimulus; model advances with the same accept rules.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic c, input logic [W-1:0] d);
    logic m_full, m_empty;
    wrreq = w; rdreq = r; clr = c; data = d;
    m_full  = (mq.size() == D);
    m_empty = (mq.size() == 0);
    if (c) begin
      model_reset();
    end else begin
      if (w && m_full)  m_ovf = 1'b1;
      if (r && m_empty) m_unf = 1'b1;
      if (r && !m_empty) m_q = mq.pop_front();
      if (w && !m_full) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wrreq = 1'b0; rdreq = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // Hand-derived vectors starting from an empty FIFO.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h00A5, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0B01, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0B02, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A5};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h0C01, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};

    // Reset state.
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: underflow with concurrent write, show-ahead head, clr priority.
    for (int i = 0; i < 6; i++) begin
      step("tbl", tbl[i].wr, tbl[i].rd, tbl[i].cl, tbl[i].d);
      chk($sformatf("tbl%0d.usedw", i), 32'(usedw0), 32'(tbl[i].e_usedw));
      chk($sformatf("tbl%0d.empty", i), 32'(empty0), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.aempty", i), 32'(aempty0), 32'(tbl[i].e_ae));
      chk($sformatf("tbl%0d.unf", i), 32'(unf0), 32'(tbl[i].e_unf));
      if (tbl[i].chk_q) chk($sformatf("tbl%0d.q", i), 32'(q0), 32'(tbl[i].e_q));
    end

    // Fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, 1'b0, W'(i));
    chk("fill.full_at_16", 32'(full0), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step("drain", 1'b0, 1'b1, 1'b0, '0);
      chk("drain.q_order", 32'(q0), 32'(i));
    end
    chk("drain.empty_after_last", 32'(empty0), 32'd1);

    // Write+read while full: write rejected, read accepted, overflow sticks.
    for (int i = 1; i <= 16; i++) step("refill", 1'b1, 1'b0, 1'b0, W'(16'h0100 + i));
    step("full_wr_rd", 1'b1, 1'b1, 1'b0, 16'hDEAD);
    chk("full_wr_rd.usedw15", 32'(usedw0), 32'd15);
    chk("full_wr_rd.ovf", 32'(ovf0), 32'd1);
    step("beef", 1'b1, 1'b0, 1'b0, 16'hBEEF);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, 1'b0, '0);
    chk("drain2.last_beef", 32'(q0), 32'h0000BEEF);
    chk("drain2.ovf_sticky", 32'(ovf0), 32'd1);

    // Pointer wrap at constant occupancy 3.
    step("clr_wrap", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 1'b0, 1'b0, W'(16'h2000 + i));
    for (int i = 3; i < 43; i++) step("wrap", 1'b1, 1'b1, 1'b0, W'(16'h2000 + i));
    chk("wrap.usedw3", 32'(usedw0), 32'd3);
    for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 1'b1, 1'b0, '0);

    // clr at usedw=9 with concurrent write/read; that write must vanish.
    for (int i = 0; i < 9; i++) step("pre_clr", 1'b1, 1'b0, 1'b0, W'(16'h3000 + i));
    step("rd_empty_arm", 1'b0, 1'b0, 1'b0, '0);
    step("clr9", 1'b1, 1'b1, 1'b1, 16'h3333);
    chk("clr9.usedw0", 32'(usedw0), 32'd0);
    chk("clr9.q0", 32'(q0), 32'd0);
    step("post_clr_wr", 1'b1, 1'b0, 1'b0, 16'h0077);
    step("post_clr_rd", 1'b0, 1'b1, 1'b0, '0);
    chk("post_clr.q", 32'(q0), 32'h00000077);

    // Asynchronous reset between edges, mid-burst.
    for (int i = 0; i < 5; i++) step("burst", 1'b1, i[0], 1'b0, W'(16'h4000 + i));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_wr", 1'b1, 1'b0, 1'b0, 16'h1234);
    step("rst_rd", 1'b0, 1'b1, 1'b0, '0);
    chk("rst.q1234", 32'(q0), 32'h00001234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
